// File: rtl/hazard_scoreboard.sv
// Register scoreboard with multi-cycle latency countdown, pipeline stall/flush control,
// EX-stage forwarding select and stall watchdog. Define HAZARD_PERF_CNT_EN for perf counters.
`timescale 1ns/1ps
module hazard_scoreboard #(
  parameter int FWD_STAGES  = 2,
  parameter int LAT_W       = 4,
  parameter int STALL_LIMIT = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_valid,
  input  logic [4:0]                        id_rs1,
  input  logic [4:0]                        id_rs2,
  input  logic                              id_use_rs1,
  input  logic                              id_use_rs2,
  input  logic                              iss_valid,
  input  logic [4:0]                        iss_rd,
  input  logic [LAT_W-1:0]                  iss_lat,
  input  logic [FWD_STAGES-1:0]             fwd_valid,
  input  logic [FWD_STAGES*5-1:0]           fwd_rd,
  input  logic                              wb_valid,
  input  logic [4:0]                        wb_rd,
  input  logic                              branch_mispredict,
  input  logic                              ext_busy,
  output logic [$clog2(FWD_STAGES+1)-1:0]   fwd_sel_rs1,
  output logic [$clog2(FWD_STAGES+1)-1:0]   fwd_sel_rs2,
  output logic                              stall_if,
  output logic                              stall_id,
  output logic                              stall_ex,
  output logic                              flush_id,
  output logic                              flush_ex,
  output logic                              stall_timeout,
  output logic [31:0]                       perf_stall_cycles,
  output logic [31:0]                       perf_flushes
);

  localparam int SEL_W = $clog2(FWD_STAGES + 1);
  localparam int WD_W  = $clog2(STALL_LIMIT + 1);
  localparam logic [LAT_W-1:0] CNT_ONE = LAT_W'(1);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(STALL_LIMIT);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);

  logic [31:0]      pend_q, pend_d;
  logic [LAT_W-1:0] cnt_q [32];
  logic [LAT_W-1:0] cnt_d [32];
  logic [4:0]       ex_rs1_q, ex_rs1_d;
  logic [4:0]       ex_rs2_q, ex_rs2_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             haz_rs1, haz_rs2, hazard;
  logic             found1, found2;

  // A source is hazardous while its producer is still counting down, including
  // a producer issuing this very cycle with nonzero latency.
  always_comb begin
    haz_rs1 = id_valid && id_use_rs1 && (id_rs1 != 5'd0) &&
              ((pend_q[id_rs1] && (cnt_q[id_rs1] != '0)) ||
               (iss_valid && (iss_rd == id_rs1) && (iss_lat != '0)));
    haz_rs2 = id_valid && id_use_rs2 && (id_rs2 != 5'd0) &&
              ((pend_q[id_rs2] && (cnt_q[id_rs2] != '0)) ||
               (iss_valid && (iss_rd == id_rs2) && (iss_lat != '0)));
    hazard  = haz_rs1 || haz_rs2;
  end

  // Priority: mispredict flush > external busy stall > hazard bubble.
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (branch_mispredict) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (ext_busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
    end else if (hazard) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    for (int unsigned r = 1; r < 32; r++) begin
      if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CNT_ONE;
    end
    if (wb_valid && (wb_rd != 5'd0)) pend_d[wb_rd] = 1'b0;
    // Applied after the writeback clear so a same-register issue wins.
    if (iss_valid && (iss_rd != 5'd0)) begin
      pend_d[iss_rd] = 1'b1;
      cnt_d[iss_rd]  = iss_lat;
    end
    pend_d[0] = 1'b0;
    cnt_d[0]  = '0;
  end

  always_comb begin
    ex_rs1_d = ex_rs1_q;
    ex_rs2_d = ex_rs2_q;
    if (flush_ex) begin
      ex_rs1_d = '0;
      ex_rs2_d = '0;
    end else if (!stall_ex) begin
      ex_rs1_d = id_use_rs1 ? id_rs1 : '0;
      ex_rs2_d = id_use_rs2 ? id_rs2 : '0;
    end
  end

  always_comb begin
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
    found1      = 1'b0;
    found2      = 1'b0;
    for (int unsigned k = 0; k < FWD_STAGES; k++) begin
      if (!found1 && fwd_valid[k] && (fwd_rd[k*5 +: 5] == ex_rs1_q) && (ex_rs1_q != 5'd0)) begin
        fwd_sel_rs1 = SEL_W'(k + 1);
        found1      = 1'b1;
      end
      if (!found2 && fwd_valid[k] && (fwd_rd[k*5 +: 5] == ex_rs2_q) && (ex_rs2_q != 5'd0)) begin
        fwd_sel_rs2 = SEL_W'(k + 1);
        found2      = 1'b1;
      end
    end
  end

  always_comb begin
    wd_d = '0;
    if (stall_id) wd_d = (wd_q >= WD_MAX) ? wd_q : wd_q + WD_ONE;
    stall_timeout = (wd_q >= WD_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      cnt_q    <= '{default: '0};
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
      wd_q     <= '0;
    end else begin
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      ex_rs1_q <= ex_rs1_d;
      ex_rs2_q <= ex_rs2_d;
      wd_q     <= wd_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + 32'(stall_id);
    perf_flush_d = perf_flush_q + 32'(branch_mispredict);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard-driven bench for hazard_scoreboard: expectations are queued as stimulus
// is driven and popped when the outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2;
  logic [4:0]  id_rs1, id_rs2;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [3:0]  iss_lat;
  logic [1:0]  fwd_valid;
  logic [9:0]  fwd_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        branch_mispredict, ext_busy;
  logic [1:0]  fwd_sel_rs1, fwd_sel_rs2;
  logic        stall_if, stall_id, stall_ex, flush_id, flush_ex, stall_timeout;
  logic [31:0] perf_stall_cycles, perf_flushes;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  hazard_scoreboard #(.FWD_STAGES(2), .LAT_W(4), .STALL_LIMIT(64)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_lat(iss_lat),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .branch_mispredict(branch_mispredict), .ext_busy(ext_busy),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .flush_ex(flush_ex),
    .stall_timeout(stall_timeout),
    .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
  );

  always #5 clk = ~clk;

  // {stall_if, stall_id, stall_ex, flush_id, flush_ex}
  localparam logic [4:0] CTL_IDLE   = 5'b00000;
  localparam logic [4:0] CTL_BUBBLE = 5'b11001;
  localparam logic [4:0] CTL_BUSY   = 5'b11100;
  localparam logic [4:0] CTL_FLUSH  = 5'b00011;

  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    iss_valid = 0; iss_rd = 0; iss_lat = 0;
    fwd_valid = 0; fwd_rd = 0; wb_valid = 0; wb_rd = 0;
    branch_mispredict = 0; ext_busy = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [31:0] val);
    exp_t x;
    x.name = name;
    x.val  = val;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    next_cycle();
    next_cycle();
    rst = 0;
    push("reset_ctl", 32'(CTL_IDLE));
    push("reset_sel", 32'd0);
    push("reset_timeout", 32'd0);
    push("reset_perf", 32'd0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if ({stall_if, stall_id, stall_ex, flush_id, flush_ex} !== e.val[4:0]) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", e.name, {stall_if, stall_id, stall_ex, flush_id, flush_ex}, e.val[4:0]);
    end
    e = exp_q.pop_front(); checks++;
    if ({fwd_sel_rs1, fwd_sel_rs2} !== e.val[3:0]) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", e.name, {fwd_sel_rs1, fwd_sel_rs2}, e.val[3:0]);
    end
    e = exp_q.pop_front(); checks++;
    if (stall_timeout !== e.val[0]) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", e.name, stall_timeout, e.val[0]);
    end
    e = exp_q.pop_front(); checks++;
    if ((perf_stall_cycles | perf_flushes) !== e.val) begin
      errors++;
      $display("FAIL %s got=%0d/%0d exp=%0d", e.name, perf_stall_cycles, perf_flushes, e.val);
    end
  endtask

  // Issue x5 with latency 3; a reader the following cycle stalls exactly 3 cycles.
  task automatic test_raw_latency();
    next_cycle();
    idle();
    iss_valid = 1; iss_rd = 5; iss_lat = 3;
    push("raw_issue_cycle", 32'(CTL_IDLE));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if ({stall_if, stall_id, stall_ex, flush_id, flush_ex} !== e.val[4:0]) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", e.name, {stall_if, stall_id, stall_ex, flush_id, flush_ex}, e.val[4:0]);
    end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      idle();
      id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
      push($sformatf("raw_read_c%0d", i), 32'((i < 3) ? CTL_BUBBLE : CTL_IDLE));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({stall_if, stall_id, stall_ex, flush_id, flush_ex} !== e.val[4:0]) begin
        errors++;
        $display("FAIL %s got=%b exp=%b", e.name, {stall_if, stall_id, stall_ex, flush_id, flush_ex}, e.val[4:0]);
      end
    end
    next_cycle();
    idle();
    wb_valid = 1; wb_rd = 5;
  endtask

  task automatic test_forwarding();
    logic [4:0] rs1_t [6] = '{5'd7, 5'd7, 5'd7, 5'd0, 5'd7, 5'd7};
    logic       u1_t  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0] rs2_t [6] = '{5'd7, 5'd7, 5'd7, 5'd7, 5'd0, 5'd12};
    logic       u2_t  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] fv_t  [6] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01};
    logic [9:0] frd_t [6] = '{{5'd7, 5'd7}, {5'd7, 5'd7}, {5'd7, 5'd9}, {5'd0, 5'd0}, {5'd7, 5'd7}, {5'd7, 5'd12}};
    logic [1:0] e1_t  [6] = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
    logic [1:0] e2_t  [6] = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1};
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      idle();
      id_valid = 1;
      id_rs1 = rs1_t[i]; id_use_rs1 = u1_t[i];
      id_rs2 = rs2_t[i]; id_use_rs2 = u2_t[i];
      fwd_valid = fv_t[i]; fwd_rd = frd_t[i];
      push($sformatf("fwd_sel_rs1_case%0d", i), 32'(e1_t[i]));
      push($sformatf("fwd_sel_rs2_case%0d", i), 32'(e2_t[i]));
      next_cycle();
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (fwd_sel_rs1 !== e.val[1:0]) begin
        errors++;
        $display("FAIL %s got=%0d exp=%0d", e.name, fwd_sel_rs1, e.val[1:0]);
      end
      e = exp_q.pop_front(); checks++;
      if (fwd_sel_rs2 !== e.val[1:0]) begin
        errors++;
        $display("FAIL %s got=%0d exp=%0d", e.name, fwd_sel_rs2, e.val[1:0]);
      end
    end
  endtask

  // x10 issued with latency 4 while ID reads it; priority of flush / busy / bubble.
  task automatic test_priority();
    logic       mp_t [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       eb_t [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] ex_t [6] = '{CTL_FLUSH, CTL_BUBBLE, CTL_BUSY, CTL_FLUSH, CTL_BUBBLE, CTL_IDLE};
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      idle();
      if (i == 0) begin
        iss_valid = 1; iss_rd = 10; iss_lat = 4;
      end
      id_valid = 1; id_rs2 = 10; id_use_rs2 = 1;
      branch_mispredict = mp_t[i];
      ext_busy = eb_t[i];
      push($sformatf("priority_c%0d", i), 32'(ex_t[i]));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({stall_if, stall_id, stall_ex, flush_id, flush_ex} !== e.val[4:0]) begin
        errors++;
        $display("FAIL %s got=%b exp=%b", e.name, {stall_if, stall_id, stall_ex, flush_id, flush_ex}, e.val[4:0]);
      end
    end
    next_cycle();
    idle();
    wb_valid = 1; wb_rd = 10;
  endtask

  // Rows: {iss_v, iss_rd, lat, wb_v, wb_rd, id_v, rs1, expected ctl}
  task automatic test_wb_iss_same();
    logic       iv_t [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [4:0] ir_t [8] = '{5'd9, 5'd0, 5'd0, 5'd0, 5'd11, 5'd0, 5'd0, 5'd0};
    logic [3:0] il_t [8] = '{4'd2, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd5};
    logic       wv_t [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [4:0] wr_t [8] = '{5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 5'd11, 5'd0, 5'd0};
    logic       dv_t [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] rs_t [8] = '{5'd0, 5'd9, 5'd9, 5'd9, 5'd0, 5'd0, 5'd11, 5'd0};
    logic [4:0] ex_t [8] = '{CTL_IDLE, CTL_BUBBLE, CTL_BUBBLE, CTL_IDLE,
                             CTL_IDLE, CTL_IDLE, CTL_IDLE, CTL_IDLE};
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      idle();
      iss_valid = iv_t[i]; iss_rd = ir_t[i]; iss_lat = il_t[i];
      wb_valid = wv_t[i]; wb_rd = wr_t[i];
      id_valid = dv_t[i]; id_rs1 = rs_t[i]; id_use_rs1 = dv_t[i];
      push($sformatf("wb_iss_c%0d", i), 32'(ex_t[i]));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({stall_if, stall_id, stall_ex, flush_id, flush_ex} !== e.val[4:0]) begin
        errors++;
        $display("FAIL %s got=%b exp=%b", e.name, {stall_if, stall_id, stall_ex, flush_id, flush_ex}, e.val[4:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    idle();
    iss_valid = 1; iss_rd = 3; iss_lat = 5;
    next_cycle();
    idle();
    id_valid = 1; id_rs1 = 3; id_use_rs1 = 1;
    push("pending_x3_stalls", 32'(CTL_BUBBLE));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if ({stall_if, stall_id, stall_ex, flush_id, flush_ex} !== e.val[4:0]) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", e.name, {stall_if, stall_id, stall_ex, flush_id, flush_ex}, e.val[4:0]);
    end
    next_cycle();
    rst = 1;
    next_cycle();
    rst = 0;
    push("x3_after_reset", 32'(CTL_IDLE));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if ({stall_if, stall_id, stall_ex, flush_id, flush_ex} !== e.val[4:0]) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", e.name, {stall_if, stall_id, stall_ex, flush_id, flush_ex}, e.val[4:0]);
    end
  endtask

  task automatic test_watchdog();
    logic [31:0] exp_stall, exp_flush;
`ifdef HAZARD_PERF_CNT_EN
    exp_stall = 32'd70;
    exp_flush = 32'd3;
`else
    exp_stall = 32'd0;
    exp_flush = 32'd0;
`endif
    next_cycle();
    idle();
    rst = 1;
    next_cycle();
    rst = 0;
    for (int n = 1; n <= 72; n++) begin
      if (n > 1) next_cycle();
      ext_busy = (n <= 70);
      push($sformatf("timeout_c%0d", n), 32'((n >= 65 && n <= 71) ? 1 : 0));
      push($sformatf("busy_ctl_c%0d", n), 32'((n <= 70) ? CTL_BUSY : CTL_IDLE));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (stall_timeout !== e.val[0]) begin
        errors++;
        $display("FAIL %s got=%b exp=%b", e.name, stall_timeout, e.val[0]);
      end
      e = exp_q.pop_front(); checks++;
      if ({stall_if, stall_id, stall_ex, flush_id, flush_ex} !== e.val[4:0]) begin
        errors++;
        $display("FAIL %s got=%b exp=%b", e.name, {stall_if, stall_id, stall_ex, flush_id, flush_ex}, e.val[4:0]);
      end
      if (n == 71) begin
        push("perf_stall_cycles", exp_stall);
        e = exp_q.pop_front(); checks++;
        if (perf_stall_cycles !== e.val) begin
          errors++;
          $display("FAIL %s got=%0d exp=%0d", e.name, perf_stall_cycles, e.val);
        end
      end
    end
    for (int n = 0; n < 4; n++) begin
      next_cycle();
      branch_mispredict = (n < 3);
    end
    push("perf_flushes", exp_flush);
    push("perf_stall_after_flush", exp_stall);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (perf_flushes !== e.val) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", e.name, perf_flushes, e.val);
    end
    e = exp_q.pop_front(); checks++;
    if (perf_stall_cycles !== e.val) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", e.name, perf_stall_cycles, e.val);
    end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_raw_latency();
    test_forwarding();
    test_priority();
    test_wb_iss_same();
    test_reset_mid();
    test_watchdog();
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=expired exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter FWD_STAGES, default 2, number of forwarding sources (1..4); index 0 is the youngest.
REQ-002 SHALL have parameter LAT_W, default 4, width of the per-register latency counter.
REQ-003 SHALL have parameter STALL_LIMIT, default 64, consecutive-stall count that raises stall_timeout.
REQ-004 SHALL have clk  in  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have id_valid  in  1  valid instruction in ID.
REQ-007 SHALL have id_rs1, id_rs2  in  5 each  ID source registers.
REQ-008 SHALL have id_use_rs1, id_use_rs2  in  1 each  the ID instruction reads that source.
REQ-009 SHALL have iss_valid, iss_rd, iss_lat  in  1/5/LAT_W  multi-cycle producer issued from EX (load, muldiv).
REQ-010 SHALL have fwd_valid, fwd_rd  in  FWD_STAGES / FWD_STAGES x 5  forwarding-source write-enables and destinations.
REQ-011 SHALL have wb_valid, wb_rd  in  1/5  register-file write in WB.
REQ-012 SHALL have branch_mispredict, ext_busy  in  1 each  mispredict resolved in EX; muldiv busy.
REQ-013 SHALL have fwd_sel_rs1, fwd_sel_rs2  out  $clog2(FWD_STAGES+1) each  0 = register file, k = source k-1.
REQ-014 SHALL have stall_if, stall_id, stall_ex, flush_id, flush_ex  out  1 each  pipeline control.
REQ-015 SHALL have stall_timeout  out  1  the stall watchdog has expired.
REQ-016 SHALL have perf_stall_cycles, perf_flushes  out  32 each  performance counters.

Function
REQ-017 SHALL hold, per register 1..31, a pending bit pend[r] and a countdown cnt[r] (LAT_W bits); r0 is never pending.
REQ-018 SHALL, when iss_valid and iss_rd!=0, set pend[iss_rd]=1 and cnt[iss_rd]=iss_lat on the next edge.
REQ-019 SHALL decrement each nonzero cnt[r] by 1 per cycle, saturating at 0.
REQ-020 SHALL clear pend[wb_rd] when wb_valid and wb_rd!=0; on a same-cycle set and clear of the same register, the set wins.
REQ-021 SHALL define hazard on a source as: id_valid, use bit set, rs!=0, pend[rs]=1 and cnt[rs]!=0; the same-cycle iss_rd match also counts when iss_lat>0.
REQ-022 SHALL, on a hazard, assert stall_if, stall_id and flush_ex (bubble) combinationally in the same cycle.
REQ-023 SHALL, on ext_busy, assert stall_if, stall_id and stall_ex; ext_busy takes priority over a hazard bubble.
REQ-024 SHALL, on branch_mispredict, assert flush_id and flush_ex and force stall_if and stall_id to 0, overriding REQ-022 and REQ-023.
REQ-025 SHALL register ex_rs1/ex_rs2, each cleared to 0 on reset or flush_ex, held on stall_ex, and otherwise loaded with id_rs (or 0 if the use bit is clear).
REQ-026 SHALL set fwd_sel_rsN = k+1 for the lowest k with fwd_valid[k], fwd_rd[k]==ex_rsN and ex_rsN!=0, else 0; this output is combinational.
REQ-027 SHALL count consecutive cycles with stall_id=1 in a saturating counter, clearing it on any cycle with stall_id=0.
REQ-028 SHALL assert stall_timeout while that counter is >= STALL_LIMIT.

Reset
REQ-029 SHALL, on rst, clear all pend, cnt, ex_rs, the watchdog and the perf counters, giving fwd_sel=0, stall_timeout=0 and all stall/flush outputs 0 in the following cycle.
REQ-030 SHALL let rst asserted mid-operation discard all pending entries, with no partial countdown surviving.

Configuration
REQ-031 SHALL, with HAZARD_PERF_CNT_EN defined, have perf_stall_cycles increment per stall_id cycle and perf_flushes per branch_mispredict cycle, both wrapping at 2^32.
REQ-032 SHALL, without HAZARD_PERF_CNT_EN, tie both perf outputs to 0 and instantiate no counter flops.

Verification
REQ-033 SHALL cover: iss x5 lat=3, then ID reads x5 -> stall_id high exactly 3 cycles, flush_ex each of those cycles, released when cnt=0.
REQ-034 SHALL cover: fwd_valid={1,1}, fwd_rd={x7,x7}, ex_rs1=x7 -> fwd_sel_rs1=1 (youngest wins); with ex_rs1=x0 -> 0.
REQ-035 SHALL cover: hazard and branch_mispredict in the same cycle -> flush_id=flush_ex=1, stall_if=stall_id=0.
REQ-036 SHALL cover: wb x9 and iss x9 lat=2 in the same cycle -> pend[x9]=1, so a read of x9 next cycle stalls.
REQ-037 SHALL cover: ext_busy held 70 cycles with STALL_LIMIT=64 -> stall_timeout rises on the 65th cycle, falls the cycle after ext_busy drops; perf_stall_cycles=70 when HAZARD_PERF_CNT_EN is defined.
REQ-038 SHALL cover: rst pulsed while x3 is pending with cnt=5 -> a read of x3 after reset does not stall.
